// File: rtl/comp_track.sv
// Registered magnitude comparator (runtime signed/unsigned) with a min/max/count tracker on `a`.
// The tracker is compiled in only when COMP_TRACK_MINMAX_EN is defined; otherwise its outputs are tied to 0.
module comp_track #(
  parameter int DATAWIDTH = 8,
  parameter int CNTW      = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 in_valid,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  input  logic                 sgn,
  input  logic                 clr,
  output logic                 out_valid,
  output logic                 gt,
  output logic                 lt,
  output logic                 eq,
  output logic [DATAWIDTH-1:0] max_val,
  output logic [DATAWIDTH-1:0] min_val,
  output logic                 track_valid,
  output logic [CNTW-1:0]      count
);

  // One extra bit lets a single signed compare serve both modes.
  function automatic logic signed [DATAWIDTH:0] f_ext(input logic [DATAWIDTH-1:0] v, input logic s);
    return $signed({s & v[DATAWIDTH-1], v});
  endfunction

  logic signed [DATAWIDTH:0] w_a_s;
  logic signed [DATAWIDTH:0] w_b_s;

  assign w_a_s = f_ext(a, sgn);
  assign w_b_s = f_ext(b, sgn);

  logic r_vld_p1;
  logic r_gt_p1;
  logic r_lt_p1;
  logic r_eq_p1;

  // Stage p0 -> p1: compare result register
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_vld_p1 <= 1'b0;
      r_gt_p1  <= 1'b0;
      r_lt_p1  <= 1'b0;
      r_eq_p1  <= 1'b0;
    end else begin
      r_vld_p1 <= in_valid;
      if (in_valid) begin
        r_gt_p1 <= (w_a_s > w_b_s);
        r_lt_p1 <= (w_a_s < w_b_s);
        r_eq_p1 <= (w_a_s == w_b_s);
      end
    end
  end

  assign out_valid = r_vld_p1;
  assign gt        = r_gt_p1;
  assign lt        = r_lt_p1;
  assign eq        = r_eq_p1;

`ifdef COMP_TRACK_MINMAX_EN
  function automatic logic [CNTW-1:0] f_sat_inc(input logic [CNTW-1:0] c);
    return (&c) ? c : c + {{(CNTW-1){1'b0}}, 1'b1};
  endfunction

  logic [DATAWIDTH-1:0]      r_max_p1;
  logic [DATAWIDTH-1:0]      r_min_p1;
  logic [CNTW-1:0]           r_cnt_p1;
  logic                      r_trk_p1;
  logic signed [DATAWIDTH:0] w_max_s;
  logic signed [DATAWIDTH:0] w_min_s;

  // Stored extremes are reinterpreted under the current sgn, never re-evaluated.
  assign w_max_s = f_ext(r_max_p1, sgn);
  assign w_min_s = f_ext(r_min_p1, sgn);

  // Stage p0 -> p1: tracker window register (r_trk_p1 is the EMPTY/ACTIVE state)
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_max_p1 <= '0;
      r_min_p1 <= '0;
      r_cnt_p1 <= '0;
      r_trk_p1 <= 1'b0;
    end else if (in_valid && (clr || !r_trk_p1)) begin
      r_max_p1 <= a;
      r_min_p1 <= a;
      r_cnt_p1 <= {{(CNTW-1){1'b0}}, 1'b1};
      r_trk_p1 <= 1'b1;
    end else if (in_valid) begin
      if (w_a_s > w_max_s) r_max_p1 <= a;
      if (w_a_s < w_min_s) r_min_p1 <= a;
      r_cnt_p1 <= f_sat_inc(r_cnt_p1);
    end else if (clr) begin
      r_max_p1 <= '0;
      r_min_p1 <= '0;
      r_cnt_p1 <= '0;
      r_trk_p1 <= 1'b0;
    end
  end

  assign max_val     = r_max_p1;
  assign min_val     = r_min_p1;
  assign count       = r_cnt_p1;
  assign track_valid = r_trk_p1;
`else
  logic w_clr_unused;

  assign w_clr_unused = clr;
  assign max_val      = '0;
  assign min_val      = '0;
  assign count        = '0;
  assign track_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_comp_track.sv
// Self-checking bench for comp_track: directed scenarios then random stimulus against a
// queue-based window model; a second instance with CNTW=2 exercises count saturation.
module tb_comp_track;
  localparam int W = 8;

  logic         Clk = 1'b0;
  logic         Rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sgn = 1'b0;
  logic         clr = 1'b0;

  logic         out_valid, gt, lt, eq, track_valid;
  logic [W-1:0] max_val, min_val;
  logic [15:0]  count;
  logic         out_valid2, gt2, lt2, eq2, track_valid2;
  logic [W-1:0] max_val2, min_val2;
  logic [1:0]   count2;

  always #5 Clk = ~Clk;

  comp_track #(.DATAWIDTH(W), .CNTW(16)) dut (
    .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .a(a), .b(b), .sgn(sgn), .clr(clr),
    .out_valid(out_valid), .gt(gt), .lt(lt), .eq(eq),
    .max_val(max_val), .min_val(min_val), .track_valid(track_valid), .count(count)
  );

  comp_track #(.DATAWIDTH(W), .CNTW(2)) dut2 (
    .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .a(a), .b(b), .sgn(sgn), .clr(clr),
    .out_valid(out_valid2), .gt(gt2), .lt(lt2), .eq(eq2),
    .max_val(max_val2), .min_val(min_val2), .track_valid(track_valid2), .count(count2)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  logic         e_ov = 1'b0, e_gt = 1'b0, e_lt = 1'b0, e_eq = 1'b0;
  logic [W-1:0] win[$];
  logic         wsgn = 1'b0;

  function automatic longint ival(input logic [W-1:0] v, input logic s);
    return (s && v[W-1]) ? longint'(v) - longint'(1 << W) : longint'(v);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    logic [W-1:0] emax, emin;
    logic [31:0]  ecnt, ecnt2, etrk;
    emax = '0; emin = '0; ecnt = 0; ecnt2 = 0; etrk = 0;
`ifdef COMP_TRACK_MINMAX_EN
    if (win.size() > 0) begin
      emax = win[0]; emin = win[0];
      foreach (win[i]) begin
        if (ival(win[i], wsgn) > ival(emax, wsgn)) emax = win[i];
        if (ival(win[i], wsgn) < ival(emin, wsgn)) emin = win[i];
      end
      etrk  = 1;
      ecnt  = (win.size() > 65535) ? 65535 : win.size();
      ecnt2 = (win.size() > 3) ? 3 : win.size();
    end
`endif
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_ov));
    chk({tag, ".gt"},        32'(gt),        32'(e_gt));
    chk({tag, ".lt"},        32'(lt),        32'(e_lt));
    chk({tag, ".eq"},        32'(eq),        32'(e_eq));
    chk({tag, ".max_val"},   32'(max_val),   32'(emax));
    chk({tag, ".min_val"},   32'(min_val),   32'(emin));
    chk({tag, ".count"},     32'(count),     ecnt);
    chk({tag, ".track"},     32'(track_valid), etrk);
    chk({tag, ".c2.ov_gt_lt_eq"}, 32'({out_valid2, gt2, lt2, eq2}), 32'({e_ov, e_gt, e_lt, e_eq}));
    chk({tag, ".c2.max_val"}, 32'(max_val2), 32'(emax));
    chk({tag, ".c2.min_val"}, 32'(min_val2), 32'(emin));
    chk({tag, ".c2.count"},   32'(count2),   ecnt2);
    chk({tag, ".c2.track"},   32'(track_valid2), etrk);
  endtask

  task automatic step(input string tag, input logic v, input logic [W-1:0] av,
                      input logic [W-1:0] bv, input logic s, input logic c);
    in_valid = v; a = av; b = bv; sgn = s; clr = c;
    @(posedge Clk);
    e_ov = v;
    if (v) begin
      e_gt = ival(av, s) >  ival(bv, s);
      e_lt = ival(av, s) <  ival(bv, s);
      e_eq = ival(av, s) == ival(bv, s);
      if (c || win.size() == 0) begin
        win.delete();
        wsgn = s;
      end
      win.push_back(av);
    end else if (c) begin
      win.delete();
    end
    #1;
    check_all(tag);
  endtask

  task automatic model_reset();
    e_ov = 1'b0; e_gt = 1'b0; e_lt = 1'b0; e_eq = 1'b0;
    win.delete();
  endtask

  initial begin
    logic         rv, rc, cur_s;
    logic [W-1:0] ra, rb;
    logic [W-1:0] edges [4];
    edges[0] = 8'h00; edges[1] = 8'h7F; edges[2] = 8'h80; edges[3] = 8'hFF;

    #12;
    check_all("reset");
    #1 Rst = 1'b1;

    step("tp1.sample", 1, 8'd5, 8'd3, 0, 0);
    step("tp1.hold",   0, 8'd0, 8'd0, 0, 0);

    step("tp2.ff_uns",   1, 8'hFF, 8'h01, 0, 0);
    step("tp2.ff_sgn",   1, 8'hFF, 8'h01, 1, 1);
    step("tp2.80_sgn",   1, 8'h80, 8'h80, 1, 0);
    step("tp2.80_uns",   1, 8'h80, 8'h80, 0, 1);

    step("tp3.clr",  0, 8'd0,   8'd0, 0, 1);
    step("tp3.u0",   1, 8'd10,  8'd0, 0, 0);
    step("tp3.u1",   1, 8'd3,   8'd0, 0, 0);
    step("tp3.u2",   1, 8'd200, 8'd0, 0, 0);
    step("tp3.u3",   1, 8'd7,   8'd0, 0, 0);
    step("tp3.s0",   1, 8'd10,  8'd0, 1, 1);
    step("tp3.s1",   1, 8'd3,   8'd0, 1, 0);
    step("tp3.s2",   1, 8'd200, 8'd0, 1, 0);
    step("tp3.s3",   1, 8'd7,   8'd0, 1, 0);

    step("tp4.clr_valid", 1, 8'd42, 8'd42, 0, 1);

    step("tp5.sat1", 1, 8'd1, 8'd3, 0, 1);
    for (int i = 2; i <= 5; i++) step("tp5.sat", 1, W'(i), 8'd3, 0, 0);

    step("tp6.pre", 1, 8'd77, 8'd12, 0, 0);
    #3 Rst = 1'b0;
    #1;
    model_reset();
    check_all("tp6.async_rst");
    #1 Rst = 1'b1;
    step("tp6.after", 1, 8'd9, 8'd9, 0, 0);

    cur_s = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rv = ($urandom_range(0, 3) != 0);
      rc = ($urandom_range(0, 15) == 0);
      ra = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : W'($urandom);
      if (rc || win.size() == 0) cur_s = 1'($urandom);
      step("rand", rv, ra, rb, cur_s, rc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
